// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-access master: state encoding,
// bus-phase lengths in half SIOC periods and the default camera address.
package sccb_pkg;

    typedef logic [3:0] sccb_state_t;

    localparam sccb_state_t ST_IDLE     = 4'd0;
    localparam sccb_state_t ST_START_A  = 4'd1;
    localparam sccb_state_t ST_START_B  = 4'd2;
    localparam sccb_state_t ST_BIT_LOW  = 4'd3;
    localparam sccb_state_t ST_BIT_HIGH = 4'd4;
    localparam sccb_state_t ST_STOP_A   = 4'd5;
    localparam sccb_state_t ST_STOP_B   = 4'd6;
    localparam sccb_state_t ST_STOP_C   = 4'd7;
    localparam sccb_state_t ST_DONE     = 4'd8;

    localparam int PH_START = 2;
    localparam int PH_BYTE  = 18;
    localparam int PH_STOP  = 3;

    localparam logic [7:0] SCCB_DEV_ADDR = 8'h42;

endpackage

// File: rtl/sccb_master_rw_if.sv
// Request/response and pad-enable bundle between the register-init sequencer,
// the SCCB master and the open-drain SIOC/SIOD pads.
interface sccb_master_rw_if #(
    parameter int ADDR_BYTES = 1
);
    logic                    start;
    logic                    rw;
    logic [8*ADDR_BYTES-1:0] address;
    logic [7:0]              wdata;
    logic                    siod_in;
    logic                    ready;
    logic [7:0]              rdata;
    logic                    rdata_valid;
    logic                    ack_err;
    logic                    SIOC_oe;
    logic                    SIOD_oe;

    modport master (
        input  start, rw, address, wdata, siod_in,
        output ready, rdata, rdata_valid, ack_err, SIOC_oe, SIOD_oe
    );

    modport slave (
        output start, rw, address, wdata, siod_in,
        input  ready, rdata, rdata_valid, ack_err, SIOC_oe, SIOD_oe
    );
endinterface

// File: rtl/sccb_phase_timer.sv
// Half-SIOC-period timer: counts 0..HALF-1 and flags the last cycle of the
// current bus phase; restart clears it on every FSM state change.
module sccb_phase_timer #(
    parameter int HALF = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase_done
);
    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign phase_done = (cnt == LAST);

endmodule

// File: rtl/sccb_master_rw.sv
// SCCB master with register read/write, 1- or 2-byte register addresses and
// optional ACK checking; drives the open-drain pads through output enables.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus free, ready for a request
// START_A   | SIOD low, SIOC high (start condition)
// START_B   | SIOC pulled low after start
// BIT_LOW   | SIOC low, SIOD set up for the next bit
// BIT_HIGH  | SIOC high, SIOD sampled on the last cycle
// STOP_A    | both lines low
// STOP_B    | SIOC released, SIOD still low
// STOP_C    | both released (bus free time), may chain into read phase 2
// DONE      | one cycle, ready and rdata_valid presented
module sccb_master_rw
    import sccb_pkg::*;
#(
    parameter int         CLK_FREQ   = 25_000_000,
    parameter int         SCCB_FREQ  = 100_000,
    parameter logic [7:0] DEV_ADDR   = SCCB_DEV_ADDR,
    parameter int         ADDR_BYTES = 1,
    parameter bit         CHECK_ACK  = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sccb_master_rw_if.master bus
);
    localparam int HALF = CLK_FREQ / (2 * SCCB_FREQ);
    localparam int AW   = 8 * ADDR_BYTES;

    if (HALF < 2) begin : g_half_chk
        $error("sccb_master_rw: CLK_FREQ/(2*SCCB_FREQ) must be at least 2");
    end
    if (ADDR_BYTES != 1 && ADDR_BYTES != 2) begin : g_addr_chk
        $error("sccb_master_rw: ADDR_BYTES must be 1 or 2");
    end

    sccb_state_t   state, state_nx;
    logic          phase_done, restart, accept;
    logic [1:0]    byte_cnt, byte_nx, last_idx;
    logic [3:0]    bit_cnt;
    logic [8:0]    tx;
    logic [7:0]    rx, load_byte;
    logic          rw_q, phase2, aborted;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          master_sent, nack, last_byte, more_phase;
    logic          ready_q, rdata_valid_q, ack_err_q, sioc_oe_q, siod_oe_q;
    logic [7:0]    rdata_q;

    sccb_phase_timer #(.HALF(HALF)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .phase_done (phase_done)
    );

    assign accept      = ready_q & bus.start;
    assign master_sent = !(phase2 && byte_cnt == 2'd1);
    assign nack        = CHECK_ACK && master_sent && bus.siod_in;
    assign last_idx    = phase2 ? 2'd1 : (rw_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1));
    assign last_byte   = (byte_cnt == last_idx);
    assign more_phase  = rw_q && !phase2 && !aborted;
    assign byte_nx     = (state == ST_BIT_HIGH) ? byte_cnt + 2'd1 : byte_cnt;
    assign restart     = (state_nx != state);

    // The read byte is loaded as all ones so its bits leave SIOD released.
    always_comb begin
        load_byte = 8'hFF;
        if (phase2) begin
            load_byte = (byte_nx == 2'd0) ? (DEV_ADDR | 8'h01) : 8'hFF;
        end else if (byte_nx == 2'd0) begin
            load_byte = DEV_ADDR;
        end else if (int'(byte_nx) <= ADDR_BYTES) begin
            load_byte = addr_q[8*(ADDR_BYTES - int'(byte_nx)) +: 8];
        end else begin
            load_byte = wdata_q;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: state_nx = accept ? ST_START_A : ST_IDLE;
            ST_START_A:  if (phase_done) state_nx = ST_START_B;
            ST_START_B:  if (phase_done) state_nx = ST_BIT_LOW;
            ST_BIT_LOW:  if (phase_done) state_nx = ST_BIT_HIGH;
            ST_BIT_HIGH: if (phase_done) begin
                if (bit_cnt == 4'd8 && (nack || last_byte)) state_nx = ST_STOP_A;
                else                                         state_nx = ST_BIT_LOW;
            end
            ST_STOP_A:   if (phase_done) state_nx = ST_STOP_B;
            ST_STOP_B:   if (phase_done) state_nx = ST_STOP_C;
            ST_STOP_C:   if (phase_done) state_nx = more_phase ? ST_START_A : ST_DONE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            tx            <= '1;
            rx            <= '0;
            rw_q          <= 1'b0;
            phase2        <= 1'b0;
            aborted       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ready_q       <= 1'b1;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ack_err_q     <= 1'b0;
            sioc_oe_q     <= 1'b0;
            siod_oe_q     <= 1'b0;
        end else begin
            state         <= state_nx;
            rdata_valid_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: if (accept) begin
                    rw_q      <= bus.rw;
                    addr_q    <= bus.address;
                    wdata_q   <= bus.wdata;
                    phase2    <= 1'b0;
                    aborted   <= 1'b0;
                    byte_cnt  <= '0;
                    ack_err_q <= 1'b0;
                    ready_q   <= 1'b0;
                    siod_oe_q <= 1'b1;
                    sioc_oe_q <= 1'b0;
                end
                ST_START_A: if (phase_done) sioc_oe_q <= 1'b1;
                ST_START_B: if (phase_done) begin
                    tx        <= {load_byte, 1'b1};
                    bit_cnt   <= '0;
                    siod_oe_q <= ~load_byte[7];
                end
                ST_BIT_LOW: if (phase_done) sioc_oe_q <= 1'b0;
                ST_BIT_HIGH: if (phase_done) begin
                    sioc_oe_q <= 1'b1;
                    if (bit_cnt != 4'd8) begin
                        rx        <= {rx[6:0], bus.siod_in};
                        tx        <= {tx[7:0], 1'b1};
                        bit_cnt   <= bit_cnt + 4'd1;
                        siod_oe_q <= ~tx[7];
                    end else if (nack) begin
                        ack_err_q <= 1'b1;
                        aborted   <= 1'b1;
                        siod_oe_q <= 1'b1;
                    end else if (last_byte) begin
                        siod_oe_q <= 1'b1;
                    end else begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        tx        <= {load_byte, 1'b1};
                        bit_cnt   <= '0;
                        siod_oe_q <= ~load_byte[7];
                    end
                end
                ST_STOP_A: if (phase_done) sioc_oe_q <= 1'b0;
                ST_STOP_B: if (phase_done) siod_oe_q <= 1'b0;
                ST_STOP_C: if (phase_done) begin
                    if (more_phase) begin
                        phase2    <= 1'b1;
                        byte_cnt  <= '0;
                        siod_oe_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        if (rw_q && phase2 && !aborted) begin
                            rdata_q       <= rx;
                            rdata_valid_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.SIOC_oe     = sioc_oe_q;
    assign bus.SIOD_oe     = siod_oe_q;

endmodule

// File: tb/tb_sccb_master_rw.sv
// Bench for sccb_master_rw: two masters (1-byte address with ACK check,
// 2-byte address without) each on a modelled open-drain bus with a slave.
module tb_sccb_master_rw;

    localparam logic [11:0] EV_S = 12'h200;
    localparam logic [11:0] EV_P = 12'h300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sccb_master_rw_if #(.ADDR_BYTES(1)) bus1 ();
    sccb_master_rw_if #(.ADDR_BYTES(2)) bus2 ();

    sccb_master_rw #(
        .CLK_FREQ(1_000_000), .SCCB_FREQ(100_000),
        .ADDR_BYTES(1), .CHECK_ACK(1'b1)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    sccb_master_rw #(
        .CLK_FREQ(1_000_000), .SCCB_FREQ(100_000),
        .ADDR_BYTES(2), .CHECK_ACK(1'b0)
    ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    // slave model state, index 0 = bus1, 1 = bus2
    logic       pull[2]   = '{1'b0, 1'b0};
    logic       prev_c[2] = '{1'b1, 1'b1};
    logic       prev_d[2] = '{1'b1, 1'b1};
    int         s_bit[2]  = '{0, 0};
    int         s_byte[2] = '{0, 0};
    logic [7:0] s_sh[2]   = '{8'h0, 8'h0};
    logic       s_rd[2]   = '{1'b0, 1'b0};
    logic       ack_en[2] = '{1'b1, 1'b1};
    logic [7:0] rd_val[2] = '{8'h00, 8'h00};

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];

    assign bus1.siod_in = ~(bus1.SIOD_oe | pull[0]);
    assign bus2.siod_in = ~(bus2.SIOD_oe | pull[1]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int b, input logic [11:0] v);
        if (b == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic push_byte(input int b, input logic [7:0] v);
        push(b, 12'h100 | {4'h0, v});
    endtask

    function automatic int qsize(input int b);
        return (b == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic sb_event(input int b, input logic [11:0] obs);
        logic [11:0] e;
        e = 12'hEEE;
        if (b == 0) begin
            if (exp_q0.size() > 0) e = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() > 0) e = exp_q1.pop_front();
        end
        chk((b == 0) ? "bus1_event" : "bus2_event", 32'(obs), 32'(e));
    endtask

    // Slave: decodes START/STOP/bytes, acks master bytes, serves read data.
    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            logic c, d;
            c = (b == 0) ? ~bus1.SIOC_oe : ~bus2.SIOC_oe;
            d = (b == 0) ? bus1.siod_in : bus2.siod_in;
            if (prev_c[b] && c && prev_d[b] && !d) begin
                sb_event(b, EV_S);
                s_bit[b]  = 0;
                s_byte[b] = 0;
                s_rd[b]   = 1'b0;
                pull[b]   = 1'b0;
            end else if (prev_c[b] && c && !prev_d[b] && d) begin
                sb_event(b, EV_P);
            end else if (!prev_c[b] && c) begin
                if (s_bit[b] < 8) begin
                    s_sh[b] = {s_sh[b][6:0], d};
                    if (s_bit[b] == 7) begin
                        sb_event(b, 12'h100 | {4'h0, s_sh[b]});
                        if (s_byte[b] == 0) s_rd[b] = s_sh[b][0];
                    end
                end else if (s_rd[b] && s_byte[b] == 1) begin
                    sb_event(b, 12'h400 | {11'h0, d});
                end
                s_bit[b]++;
            end else if (prev_c[b] && !c) begin
                if (s_bit[b] == 9) begin
                    s_bit[b] = 0;
                    s_byte[b]++;
                end
                if (s_rd[b] && s_byte[b] == 1 && s_bit[b] < 8) pull[b] = ~rd_val[b][7 - s_bit[b]];
                else if (!(s_rd[b] && s_byte[b] == 1) && s_bit[b] == 8) pull[b] = ack_en[b];
                else pull[b] = 1'b0;
            end
            if (rst) begin
                pull[b]  = 1'b0;
                s_bit[b] = 0;
            end
            prev_c[b] = c;
            prev_d[b] = (b == 0) ? bus1.siod_in : bus2.siod_in;
        end
    end

    function automatic logic [31:0] f_ready(input int b);
        return 32'((b == 0) ? bus1.ready : bus2.ready);
    endfunction
    function automatic logic [31:0] f_valid(input int b);
        return 32'((b == 0) ? bus1.rdata_valid : bus2.rdata_valid);
    endfunction
    function automatic logic [31:0] f_err(input int b);
        return 32'((b == 0) ? bus1.ack_err : bus2.ack_err);
    endfunction
    function automatic logic [31:0] f_rdata(input int b);
        return 32'((b == 0) ? bus1.rdata : bus2.rdata);
    endfunction
    function automatic logic [31:0] f_siod(input int b);
        return 32'((b == 0) ? bus1.SIOD_oe : bus2.SIOD_oe);
    endfunction

    task automatic set_req(input int b, input logic s, input logic r,
                           input logic [15:0] a, input logic [7:0] d);
        if (b == 0) begin
            bus1.start = s; bus1.rw = r; bus1.address = a[7:0]; bus1.wdata = d;
        end else begin
            bus2.start = s; bus2.rw = r; bus2.address = a;      bus2.wdata = d;
        end
    endtask

    task automatic run_txn(input int b, input logic r, input logic [15:0] a, input logic [7:0] d,
                           input int exp_n, input logic exp_valid, input logic [7:0] exp_rd,
                           input logic exp_err, input int poke);
        int n;
        int vcnt;
        vcnt = 0;
        @(negedge clk);
        set_req(b, 1'b1, r, a, d);
        @(posedge clk); #1;
        set_req(b, 1'b0, ~r, ~a, ~d);
        n = 1;
        chk("busy_at_1", f_ready(b), 0);
        chk("start_a_siod", f_siod(b), 1);
        chk("ack_err_clr", f_err(b), 0);
        while (f_ready(b) == 0 && n < 2000) begin
            if (n == poke) set_req(b, 1'b1, ~r, ~a, ~d);
            else if (n == poke + 1) set_req(b, 1'b0, ~r, ~a, ~d);
            if (f_valid(b) != 0) vcnt++;
            @(posedge clk); #1;
            n++;
        end
        chk("ready_cycle", n, exp_n);
        chk("rdata_valid", f_valid(b), 32'(exp_valid));
        chk("rdata", f_rdata(b), 32'(exp_rd));
        chk("ack_err", f_err(b), 32'(exp_err));
        chk("early_valid", vcnt, 0);
        @(posedge clk); #1;
        chk("valid_pulse_end", f_valid(b), 0);
        chk("sb_left", qsize(b), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", f_ready(0), 1);
        chk("rst_rdata", f_rdata(0), 0);
        chk("rst_valid", f_valid(0), 0);
        chk("rst_ack_err", f_err(0), 0);
        chk("rst_sioc", 32'(bus1.SIOC_oe), 0);
        chk("rst_siod", f_siod(0), 0);
        chk("rst_ready2", f_ready(1), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // plain write
        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h12); push_byte(0, 8'h80); push(0, EV_P);
        run_txn(0, 1'b0, 16'h0012, 8'h80, 296, 1'b0, 8'h00, 1'b0, -1);

        // two-phase read
        rd_val[0] = 8'hA5;
        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h0A); push(0, EV_P);
        push(0, EV_S); push_byte(0, 8'h43); push_byte(0, 8'hA5); push(0, 12'h401); push(0, EV_P);
        run_txn(0, 1'b1, 16'h000A, 8'h00, 411, 1'b1, 8'hA5, 1'b0, -1);

        // start during a busy write is ignored; rdata holds
        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h34); push_byte(0, 8'h5C); push(0, EV_P);
        run_txn(0, 1'b0, 16'h0034, 8'h5C, 296, 1'b0, 8'hA5, 1'b0, 50);

        // slave never acks: abort after device address
        ack_en[0] = 1'b0;
        push(0, EV_S); push_byte(0, 8'h42); push(0, EV_P);
        run_txn(0, 1'b0, 16'h0012, 8'h80, 116, 1'b0, 8'hA5, 1'b1, -1);

        // acking again: the accepted start clears ack_err
        ack_en[0] = 1'b1;
        rd_val[0] = 8'h3C;
        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h55); push(0, EV_P);
        push(0, EV_S); push_byte(0, 8'h43); push_byte(0, 8'h3C); push(0, 12'h401); push(0, EV_P);
        run_txn(0, 1'b1, 16'h0055, 8'h00, 411, 1'b1, 8'h3C, 1'b0, -1);

        // reset in the middle of a read (cycle 200 is STOP_B of phase 1)
        rd_val[0] = 8'h99;
        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h0A); push(0, EV_P);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 16'h000A, 8'h00);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
        n = 1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_rst_siod", f_siod(0), 1);
        chk("pre_rst_ready", f_ready(0), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sioc", 32'(bus1.SIOC_oe), 0);
        chk("mid_rst_siod", f_siod(0), 0);
        chk("mid_rst_ready", f_ready(0), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("sb_left_rst", qsize(0), 0);

        push(0, EV_S); push_byte(0, 8'h42); push_byte(0, 8'h77); push_byte(0, 8'hE1); push(0, EV_P);
        run_txn(0, 1'b0, 16'h0077, 8'hE1, 296, 1'b0, 8'h00, 1'b0, -1);

        // two-byte register address, MSB first
        push(1, EV_S); push_byte(1, 8'h42); push_byte(1, 8'h30); push_byte(1, 8'h0A);
        push_byte(1, 8'h01); push(1, EV_P);
        run_txn(1, 1'b0, 16'h300A, 8'h01, 386, 1'b0, 8'h00, 1'b0, -1);

        // no ACK check: a silent slave does not abort
        ack_en[1] = 1'b0;
        push(1, EV_S); push_byte(1, 8'h42); push_byte(1, 8'hBE); push_byte(1, 8'hEF);
        push_byte(1, 8'h99); push(1, EV_P);
        run_txn(1, 1'b0, 16'hBEEF, 8'h99, 386, 1'b0, 8'h00, 1'b0, -1);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
